// File: rtl/arb8_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : arb8_ctrl_if
//  Description : Request/grant bundle between eight clients and arb8_ctrl.
//                master : client side (drives req/done, observes the grant)
//                slave  : arbiter side (observes req/done, drives the grant)
//  Signals     : req[7:0]    request vector, bit i = client i
//                done        current owner releases the resource
//                gnt[7:0]    one-hot grant, zero when no grant is held
//                gnt_id[2:0] binary index of the granted client
//                gnt_valid   a grant is held
//                tmo         one-cycle pulse on timeout revocation
//  Revision    : 1.0 - initial release
// ============================================================================
interface arb8_ctrl_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       tmo;

  modport master (
    output req, done,
    input  gnt, gnt_id, gnt_valid, tmo
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, gnt_valid, tmo
  );
endinterface
`default_nettype wire

// File: rtl/arb8_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : arb8_ctrl
//  Description : Eight-requester arbiter for one shared resource. Samples the
//                request vector in IDLE, registers a one-hot grant and index,
//                and holds it until done, owner withdrawal or timeout. A
//                release is always followed by at least one IDLE cycle.
//  Parameters  : TIMEOUT (1..255) maximum cycles one grant may be held
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - arb8_ctrl_if.slave (req, done in; gnt, gnt_id,
//                       gnt_valid, tmo out, all registered)
//  Build macro : ARB8_ROUND_ROBIN_EN - round-robin search starting below the
//                last granted id; undefined gives fixed priority (7 highest)
//  Revision    : 1.0 - initial release
// ============================================================================
module arb8_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  arb8_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] hold_cnt;
  logic [2:0] win_id;
  logic       win_any;
  logic       owner_req;
  logic       at_limit;
  logic       release_now;

  assign win_any     = |bus.req;
  assign owner_req   = bus.req[bus.gnt_id];
  assign at_limit    = (hold_cnt == HOLD_LIMIT);
  assign release_now = bus.done || !owner_req || at_limit;

`ifdef ARB8_ROUND_ROBIN_EN
  logic [2:0] rr_ptr;
  logic [2:0] rr_cand;

  // Walk offsets 8 down to 1 so the nearest candidate below the pointer is
  // written last and wins; offset 8 wraps to the pointer itself (lowest).
  always_comb begin
    win_id  = rr_ptr;
    rr_cand = rr_ptr;
    for (int i = 8; i >= 1; i--) begin
      rr_cand = rr_ptr - 3'(i);
      if (bus.req[rr_cand]) win_id = rr_cand;
    end
  end
`else
  // Ascending scan: the highest set index is written last and wins.
  always_comb begin
    win_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.req[i]) win_id = 3'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      bus.gnt       <= 8'h00;
      bus.gnt_id    <= 3'd0;
      bus.gnt_valid <= 1'b0;
      bus.tmo       <= 1'b0;
      hold_cnt      <= 8'd0;
`ifdef ARB8_ROUND_ROBIN_EN
      rr_ptr        <= 3'd0;
`endif
    end else begin
      bus.tmo <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_any) begin
            state         <= S_GRANT;
            bus.gnt       <= 8'h01 << win_id;
            bus.gnt_id    <= win_id;
            bus.gnt_valid <= 1'b1;
            hold_cnt      <= 8'd0;
`ifdef ARB8_ROUND_ROBIN_EN
            rr_ptr        <= win_id;
`endif
          end
        end
        S_GRANT: begin
          if (release_now) begin
            state         <= S_IDLE;
            bus.gnt       <= 8'h00;
            bus.gnt_id    <= 3'd0;
            bus.gnt_valid <= 1'b0;
            hold_cnt      <= 8'd0;
            // Timeout is only flagged when nothing else ended the grant.
            bus.tmo       <= at_limit && !bus.done && owner_req;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arb8_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb8_ctrl
//  Description : Self-checking bench for arb8_ctrl (TIMEOUT = 4). Each test
//                pushes the expected winner id into a queue; a monitor pops
//                and compares whenever a new grant appears, and also checks
//                the one-hot grant invariant every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb8_ctrl;

  localparam int unsigned TO = 4;

  logic clk;
  logic rst;
  arb8_ctrl_if bus ();

  arb8_ctrl #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_q[$];
  logic       mon_en = 1'b0;
  logic       prev_valid = 1'b0;
  logic [2:0] mon_exp;

  // Monitor: samples 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      checks++;
      if (bus.gnt !== (bus.gnt_valid ? (8'h01 << bus.gnt_id) : 8'h00)) begin
        errors++;
        $display("FAIL onehot: gnt=%h gnt_id=%0d gnt_valid=%b", bus.gnt, bus.gnt_id, bus.gnt_valid);
      end
      if (bus.gnt_valid === 1'b1 && prev_valid !== 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL grant_seq: got id %0d, expected no grant", bus.gnt_id);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.gnt_id !== mon_exp) begin
            errors++;
            $display("FAIL grant_seq: got id %0d, expected %0d", bus.gnt_id, mon_exp);
          end
        end
      end
    end
    prev_valid = bus.gnt_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req = 8'h00; bus.done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_id !== 3'd0 || bus.gnt_valid !== 1'b0 || bus.tmo !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: gnt=%h id=%0d valid=%b tmo=%b, expected all 0", bus.gnt, bus.gnt_id, bus.gnt_valid, bus.tmo);
    end
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.done = (i == 2);
      tick();
      checks++;
      if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.tmo !== 1'b0) begin
        errors++;
        $display("FAIL idle_zero: cycle %0d gnt=%h valid=%b tmo=%b, expected 0", i, bus.gnt, bus.gnt_valid, bus.tmo);
      end
    end
    bus.done = 1'b0;
  endtask

  task automatic test_fixed_done();
    bus.req = 8'b0010_0110;
    exp_q.push_back(3'd5);
    tick();
    checks++;
    if (bus.gnt !== 8'h20 || bus.gnt_id !== 3'd5 || bus.gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: gnt=%h id=%0d valid=%b, expected 20/5/1", bus.gnt, bus.gnt_id, bus.gnt_valid);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.tmo !== 1'b0) begin
      errors++;
      $display("FAIL done_release: gnt=%h valid=%b tmo=%b, expected 00/0/0", bus.gnt, bus.gnt_valid, bus.tmo);
    end
`ifdef ARB8_ROUND_ROBIN_EN
    exp_q.push_back(3'd2);
`else
    exp_q.push_back(3'd5);
`endif
    tick();
    checks++;
    if (bus.gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL regrant_after_idle: valid=%b, expected 1", bus.gnt_valid);
    end
    bus.req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_timeout();
    bus.req = 8'h01;
    exp_q.push_back(3'd0);
    tick();
    for (int i = 1; i < int'(TO); i++) begin
      tick();
      checks++;
      if (bus.gnt_valid !== 1'b1 || bus.tmo !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle %0d: valid=%b tmo=%b, expected 1/0", i, bus.gnt_valid, bus.tmo);
      end
    end
    tick();
    checks++;
    if (bus.gnt_valid !== 1'b0 || bus.tmo !== 1'b1) begin
      errors++;
      $display("FAIL timeout_release: valid=%b tmo=%b, expected 0/1", bus.gnt_valid, bus.tmo);
    end
    exp_q.push_back(3'd0);
    tick();
    checks++;
    if (bus.gnt_valid !== 1'b1 || bus.tmo !== 1'b0) begin
      errors++;
      $display("FAIL timeout_regrant: valid=%b tmo=%b, expected 1/0", bus.gnt_valid, bus.tmo);
    end
    bus.req = 8'h00;
    tick();
    checks++;
    if (bus.gnt_valid !== 1'b0 || bus.tmo !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_no_tmo: valid=%b tmo=%b, expected 0/0", bus.gnt_valid, bus.tmo);
    end
    tick();
  endtask

  task automatic test_no_preempt();
    bus.req = 8'h08;
    exp_q.push_back(3'd3);
    tick();
    bus.req = 8'h88;
    tick(); tick();
    checks++;
    if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== 3'd3) begin
      errors++;
      $display("FAIL no_preempt: valid=%b id=%0d, expected 1/3", bus.gnt_valid, bus.gnt_id);
    end
    bus.req = 8'h80;
    tick();
    checks++;
    if (bus.gnt_valid !== 1'b0 || bus.tmo !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_release: valid=%b tmo=%b, expected 0/0", bus.gnt_valid, bus.tmo);
    end
    exp_q.push_back(3'd7);
    tick();
    checks++;
    if (bus.gnt !== 8'h80) begin
      errors++;
      $display("FAIL grant_after_drop: gnt=%h, expected 80", bus.gnt);
    end
    bus.req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_id;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
`ifdef ARB8_ROUND_ROBIN_EN
      exp_id = 3'(7 - g);
`else
      exp_id = 3'd7;
`endif
      exp_q.push_back(exp_id);
      tick();
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
    end
    checks++;
    if (bus.gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_final_release: valid=%b, expected 0", bus.gnt_valid);
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_reset_midgrant();
    bus.req = 8'h04;
    exp_q.push_back(3'd2);
    tick();
    tick(); tick(); tick();
    checks++;
    if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== 3'd2) begin
      errors++;
      $display("FAIL pre_reset_hold: valid=%b id=%0d, expected 1/2", bus.gnt_valid, bus.gnt_id);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_id !== 3'd0 || bus.gnt_valid !== 1'b0 || bus.tmo !== 1'b0) begin
      errors++;
      $display("FAIL midgrant_reset: gnt=%h id=%0d valid=%b tmo=%b, expected all 0", bus.gnt, bus.gnt_id, bus.gnt_valid, bus.tmo);
    end
    rst = 1'b0;
    exp_q.push_back(3'd2);
    tick();
    checks++;
    if (bus.gnt_valid !== 1'b1 || bus.gnt !== 8'h04) begin
      errors++;
      $display("FAIL resume_after_reset: valid=%b gnt=%h, expected 1/04", bus.gnt_valid, bus.gnt);
    end
    bus.req = 8'h00;
    tick(); tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 8'h00;
    bus.done = 1'b0;
    test_reset();
    test_fixed_done();
    test_timeout();
    test_no_preempt();
    test_round_robin();
    test_reset_midgrant();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_grants: %0d expected grants never seen, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arb8_ctrl.md
# arb8_ctrl

Eight-requester arbiter that shares one resource, such as a shared datapath or bus port, among up to eight clients. The block samples a request vector, picks one winner by priority encoding, and holds a registered one-hot grant plus a 3-bit grant index until the owner finishes, withdraws, or times out. It sits between the client request lines and the shared resource's select mux. Priority is fixed by default, with the highest index winning, and round-robin can be compiled in.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum cycles one grant may be held. Range 1..255.

Ports:
- `clk`  in  1  Single clock. All logic is on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `req`  in  8  Request vector. Bit i is client i.
- `done`  in  1  Current owner releases the resource. Sampled only in GRANT.
- `gnt`  out  8  One-hot grant. All zeros when no grant is held.
- `gnt_id`  out  3  Binary index of the granted client. Valid only when `gnt_valid`=1.
- `gnt_valid`  out  1  A grant is held.
- `tmo`  out  1  One-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM states: IDLE and GRANT.
- Reset: state goes to IDLE, and `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `tmo`=0, hold counter=0, round-robin pointer=0.
- IDLE:
  - If `req`≠0, select the winner, register `gnt`, `gnt_id` and `gnt_valid`=1, clear the hold counter, and go to GRANT.
  - If `req`=0, stay in IDLE with outputs at zero.
- Winner selection, fixed priority: the highest set index wins. For example, `req`=8'b0010_0110 gives winner 5.
- GRANT:
  - The grant is frozen. New or changing requests from other clients do not preempt it.
  - The hold counter increments every cycle in GRANT.
- Release conditions in GRANT, any one of:
  - `done`=1.
  - `req[gnt_id]`=0 (owner withdrew).
  - Hold counter reaches `TIMEOUT`-1.
- On release, go to IDLE and clear `gnt`, `gnt_valid` and the counter on the same edge.
- `tmo` pulses only when timeout is the sole release cause. If `done` or withdrawal coincides with timeout, `tmo`=0.
- No back-to-back grants: IDLE always lasts at least one cycle after a release, so the mux sees a guaranteed dead cycle.
- Reset asserted mid-grant: the reset values above take effect on that edge, with no `tmo` pulse.
- `done` asserted in IDLE is ignored.
- Invariant: `gnt` equals one-hot(`gnt_id`) whenever `gnt_valid`=1, and equals 0 otherwise.

## Timing
- Grant latency: `req` first nonzero at edge N gives `gnt_valid`=1 after edge N+1, one registered cycle.
- Release latency: release condition sampled at edge M gives `gnt_valid`=0 after edge M+1.
- Earliest next grant is after edge M+2.
- Maximum hold is exactly `TIMEOUT` cycles of `gnt_valid`=1.
- `tmo` is high for exactly the cycle in which `gnt_valid` first reads 0.
- All outputs are registered, with no combinational path from `req` or `done` to any output.

## Configuration
- `ARB8_ROUND_ROBIN_EN` defined:
  - A 3-bit pointer stores the last granted id k, updated when each grant is issued.
  - Search order is k-1, k-2, …, wrapping 0→7, with k itself last.
  - With the reset pointer at 0, the first search order is 7,6,…,0, which matches fixed priority.
- `ARB8_ROUND_ROBIN_EN` undefined:
  - Pure fixed priority (index 7 highest).
  - No pointer register is built.

## Test plan
1. Reset, then `req`=8'h00 for 5 cycles -> `gnt`=0, `gnt_valid`=0 and `tmo`=0 throughout.
2. `req`=8'b0010_0110, held -> one cycle later `gnt`=8'h20 and `gnt_id`=5. Pulse `done` -> `gnt`=0 on the next cycle, one IDLE cycle, then a regrant to 5 in fixed mode.
3. `TIMEOUT`=4, `req`=8'h01 held, `done`=0 -> `gnt_valid`=1 for exactly 4 cycles, then `gnt_valid`=0 with `tmo`=1 for one cycle, then a regrant to 0.
4. Granted to 3 with `req`=8'h08; raise `req[7]` mid-grant -> no preemption. Drop `req[3]` -> release, then a grant to 7 two cycles after the drop.
5. Round-robin build, `req`=8'hFF held, `done` pulsed every grant -> grant sequence 7,6,5,4,3,2,1,0,7. Fixed build gives 7 every time.
6. `rst` asserted while granted to 2 with the counter at 3 -> on the next edge all outputs are 0 and `tmo`=0, and a grant resumes one cycle after `rst` drops.
